lifo_mc: RTL
============

Name: lifo_mc

Overview:
Multi-channel LIFO. CHANNELS independent stacks share one memory array, and each channel is 2**AWIDTH words deep. There is one push port and one pop port per cycle, each with its own channel select. Per-channel status vectors extend the single-channel LIFO flag set. The block is used for per-context scratch stacks in the datapath.

Parameters:
DWIDTH, 16, data word width
AWIDTH, 8, log2 of per-channel depth
CHANNELS, 4, number of stacks (>=1)
CWIDTH, $clog2(CHANNELS) (min 1), channel index width, derived (localparam)
ALMOST_FULL, 2**AWIDTH-2, almost_full threshold (usedw >= value)
ALMOST_EMPTY, 2, almost_empty threshold (usedw <= value)

Ports:
clk_i  in  1  clock
srst_i  in  1  synchronous reset, active-high
wrreq_i  in  1  push request
wr_ch_i  in  CWIDTH  push channel
data_i  in  DWIDTH  push data
rdreq_i  in  1  pop request
rd_ch_i  in  CWIDTH  pop channel
q_o  out  DWIDTH  popped data, registered
q_valid_o  out  1  q_o updated this cycle
q_ch_o  out  CWIDTH  channel of q_o
usedw_o  out  CHANNELS*(AWIDTH+1)  per-channel fill count; channel c occupies bits [c*(AWIDTH+1) +: AWIDTH+1]
empty_o  out  CHANNELS  per-channel empty
almost_empty_o  out  CHANNELS  per-channel almost empty
almost_full_o  out  CHANNELS  per-channel almost full
full_o  out  CHANNELS  per-channel full

Behaviour:
- Clock and reset: one clock, clk_i. srst_i is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - usedw = 0, empty = all 1, almost_empty = all 1, almost_full = all 0, full = all 0.
  - q_o = 0, q_valid_o = 0, q_ch_o = 0.
  - Memory contents are not cleared.
- Reset mid-operation: all pointers return to 0 on the next edge and any same-cycle request is discarded.
- Valid push: wrreq_i && !full[wr_ch_i]. Valid pop: rdreq_i && !empty[rd_ch_i]. Both are evaluated against the registered flags.
- Valid push to a non-full channel:
  - mem[{wr_ch, usedw}] <= data_i
  - usedw[wr_ch] += 1
- Valid pop:
  - q_o <= mem[{rd_ch, usedw-1}] and usedw[rd_ch] -= 1.
  - q_valid_o = 1 and q_ch_o = rd_ch_i, both in the cycle after the request (1-cycle latency).
- q_o holds its last value when there is no valid pop.
- Invalid requests are dropped silently with no state change:
  - push to a full channel
  - pop from an empty channel (q_valid_o stays 0)
- Simultaneous valid push and pop, same channel:
  - data_i is bypassed to q_o next cycle.
  - Memory and usedw are unchanged.
- Same channel, full: the push is invalid, so only the pop proceeds (usedw -1, q_o = top).
- Same channel, empty: the pop is invalid, so only the push proceeds (usedw 0 -> 1, q_valid_o = 0).
- Different channels: push and pop proceed independently in the same cycle. The memory therefore needs 1 write port and 1 read port.
- Flags are derived from the registered usedw and reflect the count after the edge:
  - full = (usedw == 2**AWIDTH)
  - empty = (usedw == 0)
  - almost_full = (usedw >= ALMOST_FULL)
  - almost_empty = (usedw <= ALMOST_EMPTY)
- Channel index >= CHANNELS (non-power-of-2 CHANNELS): the request is treated as invalid and dropped.
- Per-channel counters never wrap. Saturation is guaranteed by the full/empty gating.

Optional Feature:
Macro LIFO_MC_ERR_FLAGS_EN.
- Defined:
  - Adds ports ovf_o[CHANNELS] and udf_o[CHANNELS], sticky per channel.
  - ovf is set on a push to a full channel; udf is set on a pop from an empty channel.
  - Both are cleared only by srst_i.
  - Dropped requests still do not change data state.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package lifo_mc_pkg holds:
  - the typedefs for channel index, count (AWIDTH+1) and data word, parameterised via localparams or the module's own parameter overrides
  - the helper function for per-channel flag computation
- Sub-module lifo_mc_chan: per-channel counter plus flag registers, instantiated CHANNELS times by generate.
- The top level owns the memory, the read register and the bypass mux.

Test Plan:
All scenarios use DWIDTH=16, AWIDTH=3, CHANNELS=4, ALMOST_FULL=6, ALMOST_EMPTY=2, with a bench queue model per channel. Every cycle the bench checks q_o, q_valid_o, q_ch_o, usedw_o and all flags.
1. Push 0x0001..0x0008 to ch2, then pop 8 times -> q_o = 0x0008..0x0001 one cycle after each pop. full_o[2] = 1 after the 8th push; almost_full_o[2] = 1 from count 6; other channels stay empty.
2. Push 10 words to ch0 -> last 2 dropped, usedw[0] = 8. Pop 10 -> 8 valid pops, then q_valid_o = 0 and usedw stays 0. With LIFO_MC_ERR_FLAGS_EN, ovf_o[0] = 1 and udf_o[0] = 1.
3. ch1 holds 3 words. Push 0xBEEF and pop ch1 in the same cycle -> q_o = 0xBEEF, q_ch_o = 1, usedw[1] stays 3.
4. Push ch3 and pop ch0 in the same cycle with ch0 holding [0x00AA] -> q_o = 0x00AA, usedw[0] = 0, usedw[3] = 1.
5. srst_i asserted mid-burst while filling ch0 and ch1 -> next cycle all usedw = 0, empty_o = 4'b1111, q_valid_o = 0.
6. 5000 cycles of random wrreq/rdreq/channels, including full and empty edges -> zero mismatches against the model.

Source files
------------

// File: rtl/lifo_mc_pkg.sv
// Shared types and flag helper for the multi-channel LIFO.
package lifo_mc_pkg;

   localparam int DWIDTH_DEF   = 16;
   localparam int AWIDTH_DEF   = 8;
   localparam int CHANNELS_DEF = 4;
   localparam int CWIDTH_DEF   = (CHANNELS_DEF > 1) ? $clog2(CHANNELS_DEF) : 1;

   typedef logic [CWIDTH_DEF-1:0] chan_t;
   typedef logic [AWIDTH_DEF:0]   count_t;
   typedef logic [DWIDTH_DEF-1:0] data_t;

   typedef struct packed {
      logic empty;
      logic almost_empty;
      logic almost_full;
      logic full;
   } flags_t;

   function automatic flags_t calc_flags(
      input int unsigned cnt,
      input int unsigned depth,
      input int unsigned af_thr,
      input int unsigned ae_thr
   );
      flags_t f;
      f.empty        = (cnt == 32'd0);
      f.almost_empty = (cnt <= ae_thr);
      f.almost_full  = (cnt >= af_thr);
      f.full         = (cnt == depth);
      return f;
   endfunction

endpackage

// File: rtl/lifo_mc_chan.sv
// One channel's fill counter, stack pointers and registered status flags.
module lifo_mc_chan
   import lifo_mc_pkg::*;
#(
   parameter int AWIDTH       = 8,
   parameter int ALMOST_FULL  = 2**AWIDTH - 2,
   parameter int ALMOST_EMPTY = 2
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              inc_i,
   input  logic              dec_i,
   output logic [AWIDTH:0]   usedw_o,
   output logic [AWIDTH-1:0] wr_ptr_o,
   output logic [AWIDTH-1:0] top_ptr_o,
   output logic              empty_o,
   output logic              almost_empty_o,
   output logic              almost_full_o,
   output logic              full_o
);

   localparam int unsigned     DEPTH   = 2**AWIDTH;
   localparam logic [AWIDTH:0]   CNT_ONE = (AWIDTH+1)'(1'b1);
   localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1'b1);

   logic [AWIDTH:0] r_cnt;
   logic [AWIDTH:0] w_cnt_nxt;
   flags_t          r_flags;
   flags_t          w_flags_nxt;

   // next count and the flags it implies
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (inc_i && !dec_i) begin
         w_cnt_nxt = r_cnt + CNT_ONE;
      end else if (dec_i && !inc_i) begin
         w_cnt_nxt = r_cnt - CNT_ONE;
      end else begin
         w_cnt_nxt = r_cnt;
      end
      w_flags_nxt = calc_flags(32'(w_cnt_nxt), DEPTH, ALMOST_FULL, ALMOST_EMPTY);
   end

   // counter and flag registers
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_cnt                <= '0;
         r_flags.empty        <= 1'b1;
         r_flags.almost_empty <= 1'b1;
         r_flags.almost_full  <= 1'b0;
         r_flags.full         <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_flags <= w_flags_nxt;
      end
   end

   // Low bits wrap to the right slot: a full count yields top = DEPTH-1.
   assign usedw_o        = r_cnt;
   assign wr_ptr_o       = r_cnt[AWIDTH-1:0];
   assign top_ptr_o      = r_cnt[AWIDTH-1:0] - PTR_ONE;
   assign empty_o        = r_flags.empty;
   assign almost_empty_o = r_flags.almost_empty;
   assign almost_full_o  = r_flags.almost_full;
   assign full_o         = r_flags.full;

endmodule

// File: rtl/lifo_mc.sv
// Multi-channel LIFO: shared stack memory, per-channel counters, registered pop port.
// Optional sticky overflow/underflow flags enabled by LIFO_MC_ERR_FLAGS_EN.
module lifo_mc
   import lifo_mc_pkg::*;
#(
   parameter int  DWIDTH       = 16,
   parameter int  AWIDTH       = 8,
   parameter int  CHANNELS     = 4,
   parameter int  ALMOST_FULL  = 2**AWIDTH - 2,
   parameter int  ALMOST_EMPTY = 2,
   localparam int CWIDTH       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                         clk_i,
   input  logic                         srst_i,
   input  logic                         wrreq_i,
   input  logic [CWIDTH-1:0]            wr_ch_i,
   input  logic [DWIDTH-1:0]            data_i,
   input  logic                         rdreq_i,
   input  logic [CWIDTH-1:0]            rd_ch_i,
   output logic [DWIDTH-1:0]            q_o,
   output logic                         q_valid_o,
   output logic [CWIDTH-1:0]            q_ch_o,
   output logic [CHANNELS*(AWIDTH+1)-1:0] usedw_o,
   output logic [CHANNELS-1:0]          empty_o,
   output logic [CHANNELS-1:0]          almost_empty_o,
   output logic [CHANNELS-1:0]          almost_full_o,
`ifdef LIFO_MC_ERR_FLAGS_EN
   output logic [CHANNELS-1:0]          full_o,
   output logic [CHANNELS-1:0]          ovf_o,
   output logic [CHANNELS-1:0]          udf_o
`else
   output logic [CHANNELS-1:0]          full_o
`endif
);

   localparam int                MAW       = CWIDTH + AWIDTH;
   localparam int                MEM_WORDS = CHANNELS * (2**AWIDTH);
   localparam logic [CWIDTH:0]   CH_LIMIT  = CHANNELS[CWIDTH:0];

   logic [DWIDTH-1:0] r_mem [MEM_WORDS];
   logic [DWIDTH-1:0] r_q;
   logic              r_q_valid;
   logic [CWIDTH-1:0] r_q_ch;

   logic [AWIDTH:0]   w_cnt     [CHANNELS];
   logic [AWIDTH-1:0] w_wr_ptr_a[CHANNELS];
   logic [AWIDTH-1:0] w_top_ptr_a[CHANNELS];
   logic [CHANNELS-1:0] w_empty;
   logic [CHANNELS-1:0] w_aempty;
   logic [CHANNELS-1:0] w_afull;
   logic [CHANNELS-1:0] w_full;
   logic [CHANNELS-1:0] w_inc;
   logic [CHANNELS-1:0] w_dec;

   logic            w_wr_ch_ok;
   logic            w_rd_ch_ok;
   logic            w_push_v;
   logic            w_pop_v;
   logic            w_bypass;
   logic [MAW-1:0]  w_wr_addr;
   logic [MAW-1:0]  w_rd_addr;

   // request qualification against registered flags
   always_comb begin
      w_wr_ch_ok = ({1'b0, wr_ch_i} < CH_LIMIT);
      w_rd_ch_ok = ({1'b0, rd_ch_i} < CH_LIMIT);
      w_push_v   = 1'b0;
      w_pop_v    = 1'b0;
      if (w_wr_ch_ok) begin
         w_push_v = wrreq_i && !w_full[wr_ch_i];
      end else begin
         w_push_v = 1'b0;
      end
      if (w_rd_ch_ok) begin
         w_pop_v = rdreq_i && !w_empty[rd_ch_i];
      end else begin
         w_pop_v = 1'b0;
      end
      w_bypass  = w_push_v && w_pop_v && (wr_ch_i == rd_ch_i);
      w_wr_addr = {wr_ch_i, w_wr_ptr_a[wr_ch_i]};
      w_rd_addr = {rd_ch_i, w_top_ptr_a[rd_ch_i]};
   end

   genvar c;
   generate
      for (c = 0; c < CHANNELS; c = c + 1) begin : g_chan
         // A same-channel push+pop is a pure bypass: the count does not move.
         assign w_inc[c] = w_push_v && !w_bypass && (wr_ch_i == CWIDTH'(c));
         assign w_dec[c] = w_pop_v  && !w_bypass && (rd_ch_i == CWIDTH'(c));

         lifo_mc_chan #(
            .AWIDTH       (AWIDTH),
            .ALMOST_FULL  (ALMOST_FULL),
            .ALMOST_EMPTY (ALMOST_EMPTY)
         ) u_chan (
            .clk_i          (clk_i),
            .srst_i         (srst_i),
            .inc_i          (w_inc[c]),
            .dec_i          (w_dec[c]),
            .usedw_o        (w_cnt[c]),
            .wr_ptr_o       (w_wr_ptr_a[c]),
            .top_ptr_o      (w_top_ptr_a[c]),
            .empty_o        (w_empty[c]),
            .almost_empty_o (w_aempty[c]),
            .almost_full_o  (w_afull[c]),
            .full_o         (w_full[c])
         );

         assign usedw_o[c*(AWIDTH+1) +: AWIDTH+1] = w_cnt[c];
      end
   endgenerate

   // stack memory write port (contents survive reset)
   always_ff @(posedge clk_i) begin
      if (!srst_i && w_push_v && !w_bypass) begin
         r_mem[w_wr_addr] <= data_i;
      end
   end

   // registered pop port with same-channel bypass
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_q       <= '0;
         r_q_valid <= 1'b0;
         r_q_ch    <= '0;
      end else begin
         r_q_valid <= w_pop_v;
         if (w_bypass) begin
            r_q    <= data_i;
            r_q_ch <= rd_ch_i;
         end else if (w_pop_v) begin
            r_q    <= r_mem[w_rd_addr];
            r_q_ch <= rd_ch_i;
         end else begin
            r_q    <= r_q;
            r_q_ch <= r_q_ch;
         end
      end
   end

`ifdef LIFO_MC_ERR_FLAGS_EN
   logic [CHANNELS-1:0] r_ovf;
   logic [CHANNELS-1:0] r_udf;

   // sticky per-channel overflow/underflow
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_ovf <= '0;
         r_udf <= '0;
      end else begin
         if (wrreq_i && w_wr_ch_ok && w_full[wr_ch_i]) begin
            r_ovf[wr_ch_i] <= 1'b1;
         end
         if (rdreq_i && w_rd_ch_ok && w_empty[rd_ch_i]) begin
            r_udf[rd_ch_i] <= 1'b1;
         end
      end
   end

   assign ovf_o = r_ovf;
   assign udf_o = r_udf;
`endif

   assign q_o            = r_q;
   assign q_valid_o      = r_q_valid;
   assign q_ch_o         = r_q_ch;
   assign empty_o        = w_empty;
   assign almost_empty_o = w_aempty;
   assign almost_full_o  = w_afull;
   assign full_o         = w_full;

endmodule
